// File: rtl/vec_serializer_pkg.sv
// vec_serializer_pkg: shared state enum, default sizes and counter-width helper
package vec_serializer_pkg;
   localparam int def_width = 32;
   localparam int def_nmsgs = 4;
   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/vec_serializer_ctrl.sv
// vec_serializer_ctrl: FSM and word counter for vec_serializer
//   clk, reset        clock, async active-high reset
//   req_val/req_rdy   upstream vector handshake
//   resp_val/resp_rdy downstream word handshake
//   resp_last         current word is the final one of the vector
//   load              capture strobe for the holding register
//   cnt               index of the word currently presented
module vec_serializer_ctrl
   import vec_serializer_pkg::*;
#(
   parameter int p_nmsgs = def_nmsgs,
   parameter int p_cw    = cnt_width(p_nmsgs)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_val,
   output logic            req_rdy,
   output logic            resp_val,
   input  logic            resp_rdy,
   output logic            resp_last,
   output logic            load,
   output logic [p_cw-1:0] cnt
);
   state_e          state, state_nxt;
   logic [p_cw-1:0] cnt_nxt;
   logic            last;
   assign last = (state == SEND) && (cnt == p_cw'(p_nmsgs - 1));
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   // leaving SEND only when the last word drains with nothing queued behind it
   always_comb begin
      state_nxt = (state == IDLE) ? (req_val ? SEND : IDLE)
                : (last && resp_rdy && !req_val) ? IDLE : SEND;
      cnt_nxt   = load ? '0 : (state == SEND && resp_rdy && !last) ? cnt + 1'b1 : cnt;
   end
   always_comb begin
      req_rdy   = (state == IDLE) || (last && resp_rdy);
      load      = req_val && req_rdy;
      resp_val  = state == SEND;
      resp_last = last;
   end
endmodule

// File: rtl/vec_serializer.sv
// vec_serializer: splits a p_nmsgs-word vector into a word-0-first stream
//   clk, reset        clock, async active-high reset
//   req_val/req_rdy   upstream vector handshake, req_msg packed vector
//   resp_val/resp_rdy downstream word handshake, resp_msg current word
//   resp_last         high on the final word of each vector
module vec_serializer
   import vec_serializer_pkg::*;
#(
   parameter int p_width = def_width,
   parameter int p_nmsgs = def_nmsgs
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       req_val,
   output logic                       req_rdy,
   input  logic [p_nmsgs*p_width-1:0] req_msg,
   output logic                       resp_val,
   input  logic                       resp_rdy,
   output logic [p_width-1:0]         resp_msg,
   output logic                       resp_last
);
   localparam int cw = cnt_width(p_nmsgs);
   logic                       load;
   logic [cw-1:0]              cnt;
   logic [p_nmsgs*p_width-1:0] hold;
   vec_serializer_ctrl #(.p_nmsgs(p_nmsgs), .p_cw(cw)) u_ctrl (
      .clk       (clk),
      .reset     (reset),
      .req_val   (req_val),
      .req_rdy   (req_rdy),
      .resp_val  (resp_val),
      .resp_rdy  (resp_rdy),
      .resp_last (resp_last),
      .load      (load),
      .cnt       (cnt)
   );
   // payload is don't-care while idle, so the holding register has no reset
   always_ff @(posedge clk)
      if (load) hold <= req_msg;
   assign resp_msg = hold[int'(cnt)*p_width +: p_width];
endmodule

// File: doc/vec_serializer.md
VEC_SERIALIZER -- requirements
Module: vec_serializer

Interface
REQ-001 Parameter p_width, default 32, bits per output word.
REQ-002 Parameter p_nmsgs, default 4, words per input vector; legal range 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_val  input  1  upstream vector valid.
REQ-006 req_rdy  output  1  serializer can accept a vector this cycle.
REQ-007 req_msg  input  p_nmsgs*p_width  packed vector; word k = bits [(k+1)*p_width-1 : k*p_width].
REQ-008 resp_val  output  1  output word valid (feeds accum req_val).
REQ-009 resp_rdy  input  1  downstream ready (from accum req_rdy).
REQ-010 resp_msg  output  p_width  current word.
REQ-011 resp_last  output  1  high while resp_msg is word p_nmsgs-1.

Function
REQ-012 Transfer occurs on an edge where val and rdy are both high; no other edge transfers data.
REQ-013 State machine SHALL have two states: IDLE (holding register empty) and SEND (holding register full).
REQ-014 IDLE: req_rdy=1, resp_val=0; req transfer -> capture req_msg into holding register, word counter=0, go to SEND.
REQ-015 SEND: resp_val=1, resp_msg = holding word[counter], resp_last = (counter==p_nmsgs-1).
REQ-016 SEND with resp transfer and counter<p_nmsgs-1 -> counter+1, stay in SEND.
REQ-017 SEND with resp transfer on last word -> if req_val, capture new vector, counter=0, stay in SEND (zero-bubble); else go to IDLE.
REQ-018 req_rdy SHALL be 1 in IDLE, and in SEND only when counter==p_nmsgs-1 and resp_rdy=1 (combinational path resp_rdy->req_rdy permitted).
REQ-019 resp_val/resp_msg/resp_last SHALL depend on registered state only, never on req_val or resp_rdy.
REQ-020 Words SHALL be emitted in order 0..p_nmsgs-1; resp_msg held stable while resp_val=1 and resp_rdy=0.
REQ-021 Counter width = max(1, clog2(p_nmsgs)); counter never exceeds p_nmsgs-1 (no wrap beyond last word).
REQ-022 Throughput: one word per cycle when resp_rdy held high; p_nmsgs cycles per vector back-to-back.
REQ-023 Latency: first word valid the cycle after the req transfer edge.
REQ-024 Data is passed through unmodified; no arithmetic on payload.

Reset
REQ-025 Asserting reset at any time SHALL force IDLE, counter=0, resp_val=0, resp_last=0, req_rdy=1 (after reset released) immediately, without waiting for a clock edge.
REQ-026 A vector in flight when reset asserts SHALL be discarded; no partial words emitted after reset.
REQ-027 Holding register contents need not be reset; resp_msg is don't-care while resp_val=0.

Structure
REQ-028 Shared package SHALL hold the state enum (IDLE, SEND) and the counter-width function; p_width/p_nmsgs defaults match accum.
REQ-029 One sub-module, vec_serializer_ctrl, SHALL hold FSM and counter; datapath (holding register, word mux) stays in top.

Verification
REQ-030 Vector {x3..x0}={10,5,10,5}, resp_rdy=1 -> resp_msg 5,10,5,10 on consecutive cycles, resp_last only on 10 (4th); feeding accum gives 30.
REQ-031 Two back-to-back vectors {11,3,10,2} then {4,8,14,18}, req_val held -> 8 consecutive words, no bubble, req_rdy high only on 4th-word cycle.
REQ-032 resp_rdy toggled 1,0,0,1,... during {1,3,13,93} -> each word held stable while stalled, order 93,13,3,1, no duplication/loss.
REQ-033 Reset asserted asynchronously after 2nd word of a vector -> resp_val drops same time step, IDLE, next vector starts from word 0.
REQ-034 Random: 100 vectors of 8-bit values, random req_val/resp_rdy -> output stream equals concatenated word-0-first inputs; with accum downstream, sums match reference model.
